// File: rtl/w_grf_writer.sv
// GRF write-port front end: merges W-stage writes with queued MDU results and tracks pending
// MDU destinations in a busy scoreboard. Define GRF_WR_TRACE_EN to print each committed write.
module w_grf_writer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_a3,
    input  logic [31:0] pipe_wd,
    input  logic [31:0] pipe_pc,
    input  logic        iss_valid,
    input  logic [4:0]  iss_a3,
    output logic        iss_ready,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_a3,
    input  logic [31:0] mdu_wd,
    input  logic [31:0] mdu_pc,
    output logic        mdu_ready,
    output logic        grf_we,
    output logic [4:0]  grf_a3,
    output logic [31:0] grf_wd,
    output logic [31:0] grf_pc,
    output logic [31:0] busy
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // FIFO storage; pointers and count alone define occupancy, so the array needs no reset
    logic [4:0]  fifo_a3_q [DEPTH];
    logic [31:0] fifo_wd_q [DEPTH];
    logic [31:0] fifo_pc_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic        grf_we_q, grf_we_d;
    logic [4:0]  grf_a3_q, grf_a3_d;
    logic [31:0] grf_wd_q, grf_wd_d;
    logic [31:0] grf_pc_q, grf_pc_d;
    logic [31:0] busy_q, busy_d;

    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        pipe_commit;
    logic        head_commit;
    logic        iss_fire;
    logic [4:0]  head_a3;
    logic [31:0] head_wd;
    logic [31:0] head_pc;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;

    assign full      = (count_q == FULL_COUNT);
    assign empty     = (count_q == '0);
    assign mdu_ready = !full;
    assign iss_ready = !(busy_q[iss_a3] && (iss_a3 != 5'd0));

    assign head_a3 = fifo_a3_q[rd_ptr_q];
    assign head_wd = fifo_wd_q[rd_ptr_q];
    assign head_pc = fifo_pc_q[rd_ptr_q];

    assign grf_we = grf_we_q;
    assign grf_a3 = grf_a3_q;
    assign grf_wd = grf_wd_q;
    assign grf_pc = grf_pc_q;
    assign busy   = busy_q;

    // Commit select: a real pipe write always wins; otherwise the FIFO head drains
    always_comb begin
        pipe_commit = pipe_we && (pipe_a3 != 5'd0);
        pop         = !pipe_commit && !empty;
        push        = mdu_valid && !full;
        head_commit = pop && (head_a3 != 5'd0);
        iss_fire    = iss_valid && iss_ready && (iss_a3 != 5'd0);

        grf_we_d = pipe_commit || head_commit;
        grf_a3_d = grf_a3_q;
        grf_wd_d = grf_wd_q;
        grf_pc_d = grf_pc_q;
        if (pipe_commit) begin
            grf_a3_d = pipe_a3;
            grf_wd_d = pipe_wd;
            grf_pc_d = pipe_pc;
        end else if (head_commit) begin
            grf_a3_d = head_a3;
            grf_wd_d = head_wd;
            grf_pc_d = head_pc;
        end

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A new issue to r in the same cycle r's old result commits must stay busy
        set_mask = '0;
        clr_mask = '0;
        if (iss_fire) begin
            set_mask[iss_a3] = 1'b1;
        end
        if (head_commit) begin
            clr_mask[head_a3] = 1'b1;
        end
        busy_d    = (busy_q & ~clr_mask) | set_mask;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            grf_we_q <= 1'b0;
            grf_a3_q <= '0;
            grf_wd_q <= '0;
            grf_pc_q <= '0;
            busy_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            grf_we_q <= grf_we_d;
            grf_a3_q <= grf_a3_d;
            grf_wd_q <= grf_wd_d;
            grf_pc_q <= grf_pc_d;
            busy_q   <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a3_q[wr_ptr_q] <= mdu_a3;
            fifo_wd_q[wr_ptr_q] <= mdu_wd;
            fifo_pc_q[wr_ptr_q] <= mdu_pc;
        end
    end

`ifdef GRF_WR_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset && grf_we_d) begin
            $display("%d@%h: $%d <= %h", $time, grf_pc_d, grf_a3_d, grf_wd_d);
        end
    end
`else
`endif

endmodule

// File: tb/tb_w_grf_writer.sv
// Scoreboard bench for w_grf_writer: stimulus queues expected commits, a negedge monitor
// pops and compares each grf_we pulse; directed checks cover busy/ready/reset behaviour.
module tb_w_grf_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pipe_we, iss_valid, iss_ready, mdu_valid, mdu_ready, grf_we;
    logic [4:0]  pipe_a3, iss_a3, mdu_a3, grf_a3;
    logic [31:0] pipe_wd, pipe_pc, mdu_wd, mdu_pc, grf_wd, grf_pc, busy;

    typedef struct packed {
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] pc;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    w_grf_writer #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .pipe_we(pipe_we), .pipe_a3(pipe_a3), .pipe_wd(pipe_wd), .pipe_pc(pipe_pc),
        .iss_valid(iss_valid), .iss_a3(iss_a3), .iss_ready(iss_ready),
        .mdu_valid(mdu_valid), .mdu_a3(mdu_a3), .mdu_wd(mdu_wd), .mdu_pc(mdu_pc),
        .mdu_ready(mdu_ready),
        .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_push(input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
        wr_t e;
        e.a3 = a3;
        e.wd = wd;
        e.pc = pc;
        exp_q.push_back(e);
    endtask

    task automatic drive_pipe(input logic we, input logic [4:0] a3, input logic [31:0] wd,
                              input logic [31:0] pc);
        pipe_we = we;
        pipe_a3 = a3;
        pipe_wd = wd;
        pipe_pc = pc;
    endtask

    task automatic drive_mdu(input logic v, input logic [4:0] a3, input logic [31:0] wd,
                             input logic [31:0] pc);
        mdu_valid = v;
        mdu_a3    = a3;
        mdu_wd    = wd;
        mdu_pc    = pc;
    endtask

    // Monitor: every committed write must match the head of the expected queue
    always @(negedge clk) begin
        wr_t e;
        if (!reset && grf_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got a3=%0d wd=%h, expected no write",
                         grf_a3, grf_wd);
            end else begin
                e = exp_q.pop_front();
                chk("commit_a3", 32'(grf_a3), 32'(e.a3));
                chk("commit_wd", grf_wd, e.wd);
                chk("commit_pc", grf_pc, e.pc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int  idx;
        logic acc;
        drive_pipe(1'b0, 5'd0, 32'h0, 32'h0);
        drive_mdu(1'b0, 5'd0, 32'h0, 32'h0);
        iss_valid = 1'b0;
        iss_a3    = 5'd0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_grf_we", 32'(grf_we), 32'd0);
        chk("rst_grf_a3", 32'(grf_a3), 32'd0);
        chk("rst_grf_wd", grf_wd, 32'd0);
        chk("rst_grf_pc", grf_pc, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_mdu_ready", 32'(mdu_ready), 32'd1);
        chk("rst_iss_ready", 32'(iss_ready), 32'd1);
        step();
        reset = 1'b0;
        step();

        // Single pipe write, one-cycle latency, then values hold
        drive_pipe(1'b1, 5'd5, 32'hDEADBEEF, 32'h0000_1000);
        exp_push(5'd5, 32'hDEADBEEF, 32'h0000_1000);
        step();
        drive_pipe(1'b0, 5'd0, 32'h0, 32'h0);
        @(negedge clk);
        chk("pipe_we", 32'(grf_we), 32'd1);
        chk("pipe_a3", 32'(grf_a3), 32'd5);
        chk("pipe_wd", grf_wd, 32'hDEADBEEF);
        step();
        @(negedge clk);
        chk("pipe_we_drop", 32'(grf_we), 32'd0);
        chk("pipe_a3_hold", 32'(grf_a3), 32'd5);
        step();

        // Issue to $8, then MDU result: commits two cycles after mdu_valid
        iss_valid = 1'b1;
        iss_a3    = 5'd8;
        @(negedge clk);
        chk("iss8_ready", 32'(iss_ready), 32'd1);
        step();
        iss_valid = 1'b0;
        @(negedge clk);
        chk("iss8_busy", busy, 32'h0000_0100);
        step();
        drive_mdu(1'b1, 5'd8, 32'h12, 32'h0000_2000);
        exp_push(5'd8, 32'h12, 32'h0000_2000);
        step();
        drive_mdu(1'b0, 5'd0, 32'h0, 32'h0);
        @(negedge clk);
        chk("mdu8_no_bypass", 32'(grf_we), 32'd0);
        chk("mdu8_busy_held", busy, 32'h0000_0100);
        step();
        @(negedge clk);
        chk("mdu8_we", 32'(grf_we), 32'd1);
        chk("mdu8_a3", 32'(grf_a3), 32'd8);
        chk("mdu8_wd", grf_wd, 32'h12);
        chk("mdu8_busy_clr", busy, 32'd0);
        step();

        // Issue blocking on busy reg, null issue, null MDU result
        iss_valid = 1'b1;
        iss_a3    = 5'd9;
        step();
        @(negedge clk);
        chk("iss9_blocked", 32'(iss_ready), 32'd0);
        step();
        iss_a3 = 5'd0;
        @(negedge clk);
        chk("iss9_busy_kept", busy, 32'h0000_0200);
        chk("iss0_ready", 32'(iss_ready), 32'd1);
        step();
        iss_valid = 1'b0;
        @(negedge clk);
        chk("iss0_busy_kept", busy, 32'h0000_0200);
        step();
        drive_mdu(1'b1, 5'd0, 32'h55, 32'h0000_3000);
        step();
        drive_mdu(1'b0, 5'd0, 32'h0, 32'h0);
        step();
        @(negedge clk);
        chk("mdu0_no_we", 32'(grf_we), 32'd0);
        chk("mdu0_ready", 32'(mdu_ready), 32'd1);
        step();
        drive_mdu(1'b1, 5'd9, 32'h99, 32'h0000_3004);
        exp_push(5'd9, 32'h99, 32'h0000_3004);
        step();
        drive_mdu(1'b0, 5'd0, 32'h0, 32'h0);
        step();
        @(negedge clk);
        chk("mdu9_busy_clr", busy, 32'd0);
        step();

        // Same-cycle issue to $7 and commit of a pending write to $7: set wins
        drive_mdu(1'b1, 5'd7, 32'h77, 32'h0000_4000);
        exp_push(5'd7, 32'h77, 32'h0000_4000);
        step();
        drive_mdu(1'b0, 5'd0, 32'h0, 32'h0);
        iss_valid = 1'b1;
        iss_a3    = 5'd7;
        @(negedge clk);
        chk("iss7_ready", 32'(iss_ready), 32'd1);
        step();
        iss_valid = 1'b0;
        @(negedge clk);
        chk("set_wins_a3", 32'(grf_a3), 32'd7);
        chk("set_wins_busy", busy, 32'h0000_0080);
        step();
        drive_mdu(1'b1, 5'd7, 32'h78, 32'h0000_4004);
        exp_push(5'd7, 32'h78, 32'h0000_4004);
        step();
        drive_mdu(1'b0, 5'd0, 32'h0, 32'h0);
        step();
        @(negedge clk);
        chk("busy7_clr", busy, 32'd0);
        step();

        // Sustained pipe writes starve the FIFO; backpressure on full, in-order drain
        for (int k = 0; k < 6; k++) exp_push(5'd3, 32'h3000 + k, 32'h500 + 4 * k);
        for (int k = 0; k < 5; k++) exp_push(5'd10 + 5'(k), 32'hA0 + k, 32'h600 + 4 * k);
        idx = 0;
        for (int k = 0; k < 6; k++) begin
            drive_pipe(1'b1, 5'd3, 32'h3000 + k, 32'h500 + 4 * k);
            if (idx < 5) drive_mdu(1'b1, 5'd10 + 5'(idx), 32'hA0 + idx, 32'h600 + 4 * idx);
            else         drive_mdu(1'b0, 5'd0, 32'h0, 32'h0);
            @(negedge clk);
            acc = mdu_ready;
            if (k == 3) chk("fill_ready_3", 32'(mdu_ready), 32'd1);
            if (k == 4) chk("full_not_ready", 32'(mdu_ready), 32'd0);
            step();
            if (mdu_valid && acc) idx++;
        end
        drive_pipe(1'b0, 5'd0, 32'h0, 32'h0);
        for (int c = 0; c < 30 && (exp_q.size() > 0 || idx < 5); c++) begin
            if (idx < 5) drive_mdu(1'b1, 5'd10 + 5'(idx), 32'hA0 + idx, 32'h600 + 4 * idx);
            else         drive_mdu(1'b0, 5'd0, 32'h0, 32'h0);
            @(negedge clk);
            acc = mdu_ready;
            step();
            if (mdu_valid && acc) idx++;
        end
        drive_mdu(1'b0, 5'd0, 32'h0, 32'h0);
        chk("drain_remaining", 32'(exp_q.size()), 32'd0);
        chk("drain_pushed", 32'(idx), 32'd5);
        @(negedge clk);
        chk("drain_ready", 32'(mdu_ready), 32'd1);
        step();

        // Reset with three queued entries and busy=0x104
        iss_valid = 1'b1;
        iss_a3    = 5'd2;
        step();
        iss_a3 = 5'd8;
        step();
        iss_valid = 1'b0;
        iss_a3    = 5'd2;
        drive_mdu(1'b1, 5'd2, 32'hA2, 32'h0000_5000);
        step();
        // Only the first pipe write becomes visible; the second is wiped by reset
        drive_pipe(1'b1, 5'd1, 32'h111, 32'h0000_5100);
        exp_push(5'd1, 32'h111, 32'h0000_5100);
        drive_mdu(1'b1, 5'd8, 32'hA8, 32'h0000_5004);
        step();
        drive_pipe(1'b1, 5'd1, 32'h222, 32'h0000_5104);
        drive_mdu(1'b1, 5'd20, 32'hB4, 32'h0000_5008);
        step();
        drive_pipe(1'b0, 5'd0, 32'h0, 32'h0);
        drive_mdu(1'b0, 5'd0, 32'h0, 32'h0);
        chk("pre_rst_busy", busy, 32'h0000_0104);
        #1 reset = 1'b1;
        #1;
        chk("midrst_busy", busy, 32'd0);
        chk("midrst_grf_we", 32'(grf_we), 32'd0);
        chk("midrst_mdu_ready", 32'(mdu_ready), 32'd1);
        chk("midrst_iss_ready", 32'(iss_ready), 32'd1);
        step();
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("post_rst_no_we", 32'(grf_we), 32'd0);
            step();
        end
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
